// File: rtl/mvm_pkg.sv
// Shared command bytes and sequencer state encoding for the MVM frame sequencer.
package mvm_pkg;

  localparam logic [7:0] CMD_FULL   = 8'hA5;
  localparam logic [7:0] CMD_X_ONLY = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    RX_K,
    RX_X,
    MVM_REQ,
    MVM_WAIT,
    TX
  } state_e;

endpackage

// File: rtl/mvm_y_serializer.sv
// Captures one result vector and streams it out one zero-extended element per byte, y[0] first.
module mvm_y_serializer #(
  parameter int R             = 2,
  parameter int W_Y_OUT       = 8,
  parameter int BITS_PER_WORD = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     capture_i,
  input  logic [R*W_Y_OUT-1:0]     y_i,
  input  logic                     m_ready_i,
  output logic [BITS_PER_WORD-1:0] m_data_o,
  output logic                     m_valid_o,
  output logic                     done_o
);

  localparam int YI_W = (R > 1) ? $clog2(R) : 1;

  logic [R*W_Y_OUT-1:0] y_q;
  logic [YI_W-1:0]      idx_q;
  logic                 active_q;
  logic                 last_byte;

  assign last_byte = (idx_q == YI_W'(R - 1));
  assign m_valid_o = active_q;
  assign done_o    = active_q && m_ready_i && last_byte;

  // NOTE: the result register is cleared on reset too, so m_data and any stale Y are known after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q      <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (capture_i) begin
      y_q      <= y_i;
      idx_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q && m_ready_i) begin
      if (last_byte) begin
        idx_q    <= '0;
        active_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  // NOTE: m_data_o gets a default before the conditional slice write so no latch is inferred.
  always_comb begin
    m_data_o = '0;
    if (active_q) begin
      m_data_o[W_Y_OUT-1:0] = y_q[int'(idx_q)*W_Y_OUT +: W_Y_OUT];
    end
  end

endmodule

// File: rtl/mvm_frame_sequencer.sv
// Parses UART command frames into K/X operands, hands them to the MVM datapath and returns Y over UART.
module mvm_frame_sequencer
  import mvm_pkg::*;
#(
  parameter int R             = 2,
  parameter int C             = 2,
  parameter int W_K           = 4,
  parameter int W_X           = 4,
  parameter int W_Y_OUT       = 8,
  parameter int BITS_PER_WORD = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  input  logic [BITS_PER_WORD-1:0] s_data,
  output logic [R*C*W_K-1:0]       mvm_k,
  output logic [C*W_X-1:0]         mvm_x,
  output logic                     mvm_valid,
  input  logic                     mvm_ready,
  input  logic                     mvm_y_valid,
  input  logic [R*W_Y_OUT-1:0]     mvm_y,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     err
);

  localparam int KI_W = (R * C > 1) ? $clog2(R * C) : 1;
  localparam int XI_W = (C > 1) ? $clog2(C) : 1;

  state_e             state_q, state_d;
  logic [KI_W-1:0]    k_idx_q, k_idx_d;
  logic [XI_W-1:0]    x_idx_q, x_idx_d;
  logic               err_q, err_d;
  logic [R*C*W_K-1:0] k_q;
  logic [C*W_X-1:0]   x_q;
  logic               k_we, x_we;
  logic               y_capture;
  logic               tx_done;
  logic               is_full_cmd, is_x_cmd;

  assign is_full_cmd = (s_data == BITS_PER_WORD'(CMD_FULL));
  assign is_x_cmd    = (s_data == BITS_PER_WORD'(CMD_X_ONLY));

  always_comb begin
    state_d   = state_q;
    k_idx_d   = k_idx_q;
    x_idx_d   = x_idx_q;
    err_d     = err_q;
    k_we      = 1'b0;
    x_we      = 1'b0;
    mvm_valid = 1'b0;
    y_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          if (is_full_cmd) begin
            state_d = RX_K;
            k_idx_d = '0;
          end else if (is_x_cmd) begin
            state_d = RX_X;
            x_idx_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RX_K: begin
        if (s_valid) begin
          k_we = 1'b1;
          if (k_idx_q == KI_W'(R * C - 1)) begin
            k_idx_d = '0;
            x_idx_d = '0;
            state_d = RX_X;
          end else begin
            k_idx_d = k_idx_q + 1'b1;
          end
        end
      end
      RX_X: begin
        if (s_valid) begin
          x_we = 1'b1;
          if (x_idx_q == XI_W'(C - 1)) begin
            x_idx_d = '0;
            state_d = MVM_REQ;
          end else begin
            x_idx_d = x_idx_q + 1'b1;
          end
        end
      end
      MVM_REQ: begin
        mvm_valid = 1'b1;
        if (mvm_ready) state_d = MVM_WAIT;
        if (s_valid)   err_d   = 1'b1;
      end
      MVM_WAIT: begin
        if (mvm_y_valid) begin
          y_capture = 1'b1;
          state_d   = TX;
        end
        if (s_valid) err_d = 1'b1;
      end
      TX: begin
        if (tx_done) state_d = IDLE;
        if (s_valid) err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_idx_q <= '0;
      x_idx_q <= '0;
      err_q   <= 1'b0;
      k_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      k_idx_q <= k_idx_d;
      x_idx_q <= x_idx_d;
      err_q   <= err_d;
      if (k_we) k_q[int'(k_idx_q)*W_K +: W_K] <= s_data[W_K-1:0];
      if (x_we) x_q[int'(x_idx_q)*W_X +: W_X] <= s_data[W_X-1:0];
    end
  end

  // Operands are only written while receiving, so they are stable across MVM_REQ.
  assign mvm_k = k_q;
  assign mvm_x = x_q;
  assign busy  = (state_q != IDLE);
  assign err   = err_q;

  mvm_y_serializer #(
    .R             (R),
    .W_Y_OUT       (W_Y_OUT),
    .BITS_PER_WORD (BITS_PER_WORD)
  ) u_y_ser (
    .clk       (clk),
    .rstn      (rstn),
    .capture_i (y_capture),
    .y_i       (mvm_y),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_valid_o (m_valid),
    .done_o    (tx_done)
  );

endmodule
